// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the dual-issue fetch queue.
// Holds the default bus widths, the queue depth, the fetch FSM state
// encodings and the packed {instruction, pc} queue entry.
package fetch_queue_pkg;

    localparam int unsigned INST_WIDTH       = 32;
    localparam int unsigned ADDR_WIDTH       = 16;
    localparam int unsigned FQ_DEPTH         = 8;

    localparam int unsigned FETCH_STATE_BITS = 2;
    localparam logic [FETCH_STATE_BITS-1:0] FETCH_IDLE = 2'd0;
    localparam logic [FETCH_STATE_BITS-1:0] FETCH_WAIT = 2'd1;
    localparam logic [FETCH_STATE_BITS-1:0] FETCH_DROP = 2'd2;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of all non-clock signals around the fetch queue.
//   control : flush, flush_address, stall              (decode/branch -> queue)
//   imem    : imem_req, imem_addr                      (queue -> memory)
//             imem_ready, imem_valid, imem_instruction0/1 (memory -> queue)
//   decode  : valid0/1, instruction0/1, pc0/1          (queue -> decode)
// slave  : the fetch queue side.
// master : the surrounding pipeline / memory side.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_address;
    logic                  stall;

    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic                  imem_valid;
    logic [INST_WIDTH-1:0] imem_instruction0;
    logic [INST_WIDTH-1:0] imem_instruction1;

    logic                  valid0;
    logic                  valid1;
    logic [INST_WIDTH-1:0] instruction0;
    logic [INST_WIDTH-1:0] instruction1;
    logic [ADDR_WIDTH-1:0] pc0;
    logic [ADDR_WIDTH-1:0] pc1;

    modport slave (
        input  flush, flush_address, stall,
        input  imem_ready, imem_valid, imem_instruction0, imem_instruction1,
        output imem_req, imem_addr,
        output valid0, valid1, instruction0, instruction1, pc0, pc1
    );

    modport master (
        output flush, flush_address, stall,
        output imem_ready, imem_valid, imem_instruction0, imem_instruction1,
        input  imem_req, imem_addr,
        input  valid0, valid1, instruction0, instruction1, pc0, pc1
    );

endinterface

// File: rtl/fetch_queue_storage.sv
// Circular entry array for the fetch queue: writes two consecutive entries
// and reads two consecutive entries per cycle, with pointer wrap modulo DEPTH.
//   clk      : clock
//   i_we     : write both entries at i_wr_ptr and i_wr_ptr+1
//   i_wr_ptr : write pointer
//   i_wdata0/1 : entries for i_wr_ptr / i_wr_ptr+1
//   i_rd_ptr : read pointer
//   o_rdata0/1 : entries at i_rd_ptr / i_rd_ptr+1 (combinational)
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_wr_ptr,
    input  fq_entry_t                i_wdata0,
    input  fq_entry_t                i_wdata1,
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    output fq_entry_t                o_rdata0,
    output fq_entry_t                o_rdata1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] w_wr_ptr1;
    logic [PTR_W-1:0] w_rd_ptr1;

    // Natural overflow of the pointer width gives the modulo-DEPTH wrap.
    assign w_wr_ptr1 = i_wr_ptr + PTR_W'(1);
    assign w_rd_ptr1 = i_rd_ptr + PTR_W'(1);

    // Data array needs no reset: validity is tracked by the queue count.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_ptr]  <= i_wdata0;
            r_mem[w_wr_ptr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_rd_ptr];
    assign o_rdata1 = r_mem[w_rd_ptr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch buffer between instruction memory and decode.
// Issues 2-word fetches (one outstanding at most), queues the returned pairs
// tagged with their PC, presents the two oldest to decode and discards
// wrong-path instructions on flush.
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-low
//   bus   : fetch_queue_if.slave (control, imem handshake, decode slots)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [FETCH_STATE_BITS-1:0] r_state;
    logic [FETCH_STATE_BITS-1:0] w_state_next;
    logic [ADDR_WIDTH-1:0]       r_fetch_pc;
    logic [ADDR_WIDTH-1:0]       r_req_addr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [CNT_W-1:0]            r_count;
    logic [CNT_W-1:0]            w_count_next;

    logic      w_valid0;
    logic      w_valid1;
    logic      w_req;
    logic      w_hs;
    logic      w_push;
    logic [1:0] w_pop;

    fq_entry_t w_wdata0;
    fq_entry_t w_wdata1;
    fq_entry_t w_rdata0;
    fq_entry_t w_rdata1;

    assign w_valid0 = (r_count != '0);
    assign w_valid1 = (r_count >= CNT_W'(2));

    // Fetch FSM: next state plus request/push/pop decode.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_push       = 1'b0;
        w_pop        = 2'd0;

        if (!bus.stall) begin
            w_pop = 2'(w_valid0) + 2'(w_valid1);
        end

        case (r_state)
            FETCH_IDLE: begin
                // Request only with two free entries, so a push never overflows.
                w_req = reset && (r_count <= CNT_W'(DEPTH - 2)) && !bus.flush;
                if (w_req && bus.imem_ready) begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (bus.imem_valid) begin
                    w_push       = !bus.flush;
                    w_state_next = FETCH_IDLE;
                end else if (bus.flush) begin
                    w_state_next = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                // A response consumes the stale request even if a new flush lands.
                if (bus.imem_valid) begin
                    w_state_next = FETCH_IDLE;
                end
            end
            default: begin
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    assign w_hs         = w_req && bus.imem_ready;
    assign w_count_next = r_count + (w_push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(w_pop);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pointers, occupancy and fetch PC; flush overrides push and pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= '0;
            r_req_addr <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.flush) begin
            r_fetch_pc <= bus.flush_address;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_count  <= w_count_next;
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(2);
            end
            if (w_hs) begin
                r_req_addr <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(2);
            end
        end
    end

    assign w_wdata0 = '{inst: bus.imem_instruction0, pc: r_req_addr};
    assign w_wdata1 = '{inst: bus.imem_instruction1, pc: r_req_addr + ADDR_WIDTH'(1)};

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .i_we     (w_push),
        .i_wr_ptr (r_wr_ptr),
        .i_wdata0 (w_wdata0),
        .i_wdata1 (w_wdata1),
        .i_rd_ptr (r_rd_ptr),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign bus.imem_req     = w_req;
    assign bus.imem_addr    = r_fetch_pc;
    assign bus.valid0       = w_valid0;
    assign bus.valid1       = w_valid1;
    assign bus.instruction0 = w_rdata0.inst;
    assign bus.instruction1 = w_rdata1.inst;
    assign bus.pc0          = w_rdata0.pc;
    assign bus.pc1          = w_rdata1.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a variable-latency memory model plus a
// queue-level reference model of fetch, buffering, pop and flush behaviour.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] inst;
        logic [15:0] pc;
    } ent_t;

    logic clk;
    logic reset;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    ent_t        mq[$];
    logic [15:0] m_fetch_pc;
    logic [15:0] m_req_addr;
    bit          m_busy;
    bit          m_discard;

    // Memory environment state.
    int          mem_cnt;
    logic [15:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input int stall_pct, input int flush_pct, input int ready_pct,
                         input int max_lat, input bit do_reset);
        bit   exp_req;
        int   pop;
        ent_t e;
        @(negedge clk);
        reset                 = !do_reset;
        bus.stall             = ($urandom_range(99) < 32'(stall_pct));
        bus.flush             = !do_reset && ($urandom_range(99) < 32'(flush_pct));
        bus.flush_address     = 16'($urandom);
        bus.imem_ready        = ($urandom_range(99) < 32'(ready_pct));
        bus.imem_valid        = 1'b0;
        bus.imem_instruction0 = $urandom;
        bus.imem_instruction1 = $urandom;
        if (do_reset) begin
            mem_cnt = 0;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_valid        = 1'b1;
                bus.imem_instruction0 = mem_word(mem_addr);
                bus.imem_instruction1 = mem_word(16'(mem_addr + 16'd1));
            end
        end
        #1;
        exp_req = !do_reset && !m_busy && (mq.size() <= DEPTH - 2) && !bus.flush;
        check("valid0", bus.valid0, mq.size() >= 1);
        check("valid1", bus.valid1, mq.size() >= 2);
        check("imem_req", bus.imem_req, exp_req);
        if (exp_req) check("imem_addr", bus.imem_addr, m_fetch_pc);
        if (mq.size() >= 1) begin
            check("pc0", bus.pc0, mq[0].pc);
            check("instruction0", bus.instruction0, mq[0].inst);
        end
        if (mq.size() >= 2) begin
            check("pc1", bus.pc1, mq[1].pc);
            check("instruction1", bus.instruction1, mq[1].inst);
        end

        if (bus.imem_req && bus.imem_ready) begin
            mem_addr = bus.imem_addr;
            mem_cnt  = int'($urandom_range(32'(max_lat), 1));
        end

        if (do_reset) begin
            mq.delete();
            m_fetch_pc = '0;
            m_busy     = 1'b0;
            m_discard  = 1'b0;
        end else if (bus.flush) begin
            mq.delete();
            m_fetch_pc = bus.flush_address;
            if (m_busy) begin
                if (bus.imem_valid) begin
                    m_busy    = 1'b0;
                    m_discard = 1'b0;
                end else begin
                    m_discard = 1'b1;
                end
            end
        end else begin
            if (!bus.stall) begin
                pop = (mq.size() < 2) ? mq.size() : 2;
                repeat (pop) void'(mq.pop_front());
            end
            if (m_busy && bus.imem_valid) begin
                if (!m_discard) begin
                    e.inst = mem_word(m_req_addr);
                    e.pc   = m_req_addr;
                    mq.push_back(e);
                    e.pc   = 16'(m_req_addr + 16'd1);
                    e.inst = mem_word(e.pc);
                    mq.push_back(e);
                end
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end
            if (exp_req && bus.imem_ready) begin
                m_busy     = 1'b1;
                m_req_addr = m_fetch_pc;
                m_fetch_pc = 16'(m_fetch_pc + 16'd2);
            end
        end
    endtask

    initial begin
        reset                 = 1'b0;
        bus.flush             = 1'b0;
        bus.flush_address     = '0;
        bus.stall             = 1'b0;
        bus.imem_ready        = 1'b0;
        bus.imem_valid        = 1'b0;
        bus.imem_instruction0 = '0;
        bus.imem_instruction1 = '0;
        mem_cnt               = 0;
        mem_addr              = '0;
        m_fetch_pc            = '0;
        m_req_addr            = '0;
        m_busy                = 1'b0;
        m_discard             = 1'b0;
        @(posedge clk);

        // Reset held for two cycles.
        repeat (2) cycle(0, 0, 0, 1, 1'b1);
        // Fill with decode stalled and single-cycle memory.
        repeat (20) cycle(100, 0, 100, 1, 1'b0);
        // Drain with refetch allowed.
        repeat (10) cycle(0, 0, 100, 1, 1'b0);
        // Fill again, then frequent flushes with slow memory.
        repeat (20) cycle(100, 0, 100, 1, 1'b0);
        repeat (300) cycle(40, 25, 80, 4, 1'b0);

        // Long random run with varying pressure and one mid-run reset.
        for (int blk = 0; blk < 15; blk++) begin
            int sp;
            sp = int'($urandom_range(90));
            for (int i = 0; i < 200; i++) begin
                cycle(sp, 4, 70, 4, (blk == 7) && (i < 2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
